bsg_axi_mem_responder: RTL and testbench
========================================

Name: bsg_axi_mem_responder

Overview:
- AXI4 slave memory model that terminates a DRAM-side master port (HP0-style, 6-bit IDs, INCR bursts) in cosim and loopback FPGA builds.
- Services one transaction at a time from an internal word array.
- Gives the PS-to-DRAM request path a self-contained responder for bring-up, so no board DRAM controller is needed.

Parameters:
data_width_p, 32, data bus width in bits; power of two, minimum 32
addr_width_p, 32, byte address width
id_width_p, 6, AXI ID width
els_p, 1024, memory depth in data_width_p words; power of two

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
s00_axi_awaddr  in  addr_width_p  write burst start byte address
s00_axi_awid  in  id_width_p  write ID
s00_axi_awlen  in  8  beats-1
s00_axi_awburst  in  2  burst type
s00_axi_awvalid  in  1  AW valid
s00_axi_awready  out  1  AW ready
s00_axi_wdata  in  data_width_p  write data
s00_axi_wstrb  in  data_width_p/8  byte enables
s00_axi_wlast  in  1  last write beat
s00_axi_wvalid  in  1  W valid
s00_axi_wready  out  1  W ready
s00_axi_bid  out  id_width_p  echoed awid
s00_axi_bresp  out  2  write response
s00_axi_bvalid  out  1  B valid
s00_axi_bready  in  1  B ready
s00_axi_araddr  in  addr_width_p  read burst start byte address
s00_axi_arid  in  id_width_p  read ID
s00_axi_arlen  in  8  beats-1
s00_axi_arburst  in  2  burst type
s00_axi_arvalid  in  1  AR valid
s00_axi_arready  out  1  AR ready
s00_axi_rdata  out  data_width_p  read data
s00_axi_rid  out  id_width_p  echoed arid
s00_axi_rresp  out  2  read response
s00_axi_rlast  out  1  last read beat
s00_axi_rvalid  out  1  R valid
s00_axi_rready  in  1  R ready

Behaviour:
- Reset (async, aresetn=0):
  - state=IDLE; all ready and valid outputs are 0; bresp/rresp/rid/bid/rdata/rlast are 0.
  - Round-robin bit selects write first.
  - Memory contents are not reset.
  - Assertion mid-burst aborts the transaction; no B or R completion is issued after reset releases.
- Size: awsize/arsize are not ports. Every beat is full width, and the master must issue size = log2(data_width_p/8).
- Word index = addr[lg(els_p)+lg(bytes)-1 : lg(bytes)]. Low byte-offset bits are ignored.
- FSM states: IDLE, WDATA, WRESP, RFETCH, RDATA.
- IDLE:
  - awready = grant_w & awvalid.
  - arready = ~grant_w & arvalid.
  - grant_w = awvalid & (~arvalid | rr_w).
  - After each granted transaction, rr flips to favour the other channel.
  - On AW handshake: capture addr, id, len, burst; err = (burst != 2'b01) | out-of-range start or end address. Go to WDATA.
  - On AR handshake: capture the same fields; go to RFETCH.
- WDATA:
  - wready=1. Each handshake writes the strobed bytes to mem[idx] unless err; idx += 1; beat counter += 1.
  - On beat == len: if wlast != 1, set err. Go to WRESP.
  - wlast asserted early (beat < len) sets err; remaining beats are still consumed.
- WRESP: bvalid=1, bid = captured id, bresp = err ? 2'b10 (SLVERR) : 2'b00. On bready, go to IDLE.
- RFETCH: one cycle. Synchronous read of mem[idx] into the output register; go to RDATA.
- RDATA:
  - rvalid=1, rid = captured id, rlast = (beat == len), rresp = err ? 2'b10 : 2'b00. rdata = 0 when err.
  - On rready: advance idx and beat, and prefetch the next word so beats sustain 1 per cycle. On the last beat go to IDLE.
  - While rready=0, rdata/rlast/rresp are held stable.
- Read latency: first rvalid 2 cycles after the AR handshake edge.
- Write turnaround: bvalid the cycle after the last W handshake.
- Out of range: start_idx + len >= els_p, or any nonzero address bits above the index field, sets err.
- Same-cycle AW and AR in IDLE: only the rr-selected channel is accepted; the other waits, its valid held by the master.
- No outstanding overlap: AW and AR are never accepted outside IDLE.

Test Plan:
- Single write: awaddr 0x10, len 0, wdata 0xDEADBEEF, wstrb 0xF, awid 5 -> bresp 0, bid 5. Read 0x10 arid 3 -> rdata 0xDEADBEEF, rlast 1, rid 3, rresp 0, rvalid 2 cycles after AR.
- Burst: write len 3 at 0x40, data 1,2,3,4. Read len 3 with rready toggling 1,0,1,0 -> beats 1,2,3,4 in order, data held while stalled, rlast only on beat 4.
- Partial strobe: 0xFFFFFFFF at 0x20, then wstrb 0x3 with 0x0000AAAA -> read returns 0xFFFFAAAA.
- Arbitration: after reset, AW and AR valid on the same edge -> write accepted first. Next simultaneous pair -> read accepted first.
- Errors, els_p=1024:
  - Write at 0x1000 -> bresp 2'b10, memory unchanged.
  - awburst 2'b10 at 0x0 -> bresp 2'b10.
  - Read 0x0FFC with len 1 -> two beats, rdata 0, rresp 2'b10.
- Reset mid-read: aresetn low during beat 2 of a len-3 read -> rvalid 0 immediately. After release, IDLE with arready ready for a new AR and no stale R beat.

Source files
------------

// File: rtl/bsg_axi_mem_responder.sv
// AXI4 slave memory model: one outstanding INCR burst at a time, serviced from an
// internal word array, with round-robin arbitration between write and read requests.
module bsg_axi_mem_responder #(
  parameter int data_width_p = 32,
  parameter int addr_width_p = 32,
  parameter int id_width_p   = 6,
  parameter int els_p        = 1024
) (
  input  logic                      aclk,
  input  logic                      aresetn,

  input  logic [addr_width_p-1:0]   s00_axi_awaddr,
  input  logic [id_width_p-1:0]     s00_axi_awid,
  input  logic [7:0]                s00_axi_awlen,
  input  logic [1:0]                s00_axi_awburst,
  input  logic                      s00_axi_awvalid,
  output logic                      s00_axi_awready,

  input  logic [data_width_p-1:0]   s00_axi_wdata,
  input  logic [data_width_p/8-1:0] s00_axi_wstrb,
  input  logic                      s00_axi_wlast,
  input  logic                      s00_axi_wvalid,
  output logic                      s00_axi_wready,

  output logic [id_width_p-1:0]     s00_axi_bid,
  output logic [1:0]                s00_axi_bresp,
  output logic                      s00_axi_bvalid,
  input  logic                      s00_axi_bready,

  input  logic [addr_width_p-1:0]   s00_axi_araddr,
  input  logic [id_width_p-1:0]     s00_axi_arid,
  input  logic [7:0]                s00_axi_arlen,
  input  logic [1:0]                s00_axi_arburst,
  input  logic                      s00_axi_arvalid,
  output logic                      s00_axi_arready,

  output logic [data_width_p-1:0]   s00_axi_rdata,
  output logic [id_width_p-1:0]     s00_axi_rid,
  output logic [1:0]                s00_axi_rresp,
  output logic                      s00_axi_rlast,
  output logic                      s00_axi_rvalid,
  input  logic                      s00_axi_rready
);

  localparam int bytes_lp    = data_width_p / 8;
  localparam int lg_bytes_lp = $clog2(bytes_lp);
  localparam int lg_els_lp   = $clog2(els_p);

  typedef enum logic [2:0] {IDLE, WDATA, WRESP, RFETCH, RDATA} state_e;

  state_e                  state_r, state_n;
  logic [lg_els_lp-1:0]    idx_r;
  logic [7:0]              beat_r, len_r;
  logic [id_width_p-1:0]   id_r;
  logic                    err_r;
  logic                    rr_w_r;
  logic [data_width_p-1:0] rdata_r;
  logic [data_width_p-1:0] mem [els_p];

  logic                    grant_w;
  logic                    last_beat;
  logic [addr_width_p-1:0] req_addr;
  logic [7:0]              req_len;
  logic [1:0]              req_burst;
  logic [id_width_p-1:0]   req_id;
  logic [lg_els_lp-1:0]    start_idx;
  logic [lg_els_lp+8:0]    end_sum;
  logic                    req_err;
  logic [data_width_p-1:0] fetch_word;

  // Handshake rule on every channel: a beat transfers on a rising edge where
  // valid and ready are both high; valid, once raised, is held until then.
  assign grant_w   = s00_axi_awvalid & (~s00_axi_arvalid | rr_w_r);
  assign req_addr  = grant_w ? s00_axi_awaddr  : s00_axi_araddr;
  assign req_len   = grant_w ? s00_axi_awlen   : s00_axi_arlen;
  assign req_burst = grant_w ? s00_axi_awburst : s00_axi_arburst;
  assign req_id    = grant_w ? s00_axi_awid    : s00_axi_arid;
  assign start_idx = req_addr[lg_els_lp+lg_bytes_lp-1 -: lg_els_lp];
  assign end_sum   = {9'b0, start_idx} + {{(lg_els_lp+1){1'b0}}, req_len};

  // Any carry past the index field, or address bits above it, means the burst leaves the array.
  assign req_err = (req_burst != 2'b01)
                 | (end_sum[lg_els_lp+8:lg_els_lp] != '0)
                 | ((req_addr >> (lg_els_lp + lg_bytes_lp)) != '0);

  assign last_beat  = (beat_r == len_r);
  assign fetch_word = err_r ? '0 : mem[idx_r];

  always_comb begin
    state_n         = state_r;
    s00_axi_awready = 1'b0;
    s00_axi_arready = 1'b0;
    s00_axi_wready  = 1'b0;
    s00_axi_bvalid  = 1'b0;
    s00_axi_rvalid  = 1'b0;
    case (state_r)
      IDLE: begin
        s00_axi_awready = grant_w & s00_axi_awvalid;
        s00_axi_arready = ~grant_w & s00_axi_arvalid;
        if (s00_axi_awready)      state_n = WDATA;
        else if (s00_axi_arready) state_n = RFETCH;
      end
      WDATA: begin
        s00_axi_wready = 1'b1;
        if (s00_axi_wvalid && last_beat) state_n = WRESP;
      end
      WRESP: begin
        s00_axi_bvalid = 1'b1;
        if (s00_axi_bready) state_n = IDLE;
      end
      RFETCH: state_n = RDATA;
      RDATA: begin
        s00_axi_rvalid = 1'b1;
        if (s00_axi_rready && last_beat) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign s00_axi_bid   = (state_r == WRESP) ? id_r : '0;
  assign s00_axi_bresp = (state_r == WRESP && err_r) ? 2'b10 : 2'b00;
  assign s00_axi_rid   = (state_r == RDATA) ? id_r : '0;
  assign s00_axi_rresp = (state_r == RDATA && err_r) ? 2'b10 : 2'b00;
  assign s00_axi_rlast = (state_r == RDATA) & last_beat;
  assign s00_axi_rdata = rdata_r;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r <= IDLE;
      rr_w_r  <= 1'b1;
      idx_r   <= '0;
      beat_r  <= '0;
      len_r   <= '0;
      id_r    <= '0;
      err_r   <= 1'b0;
      rdata_r <= '0;
    end else begin
      state_r <= state_n;
      case (state_r)
        IDLE: begin
          if (s00_axi_awready || s00_axi_arready) begin
            rr_w_r <= ~grant_w;
            idx_r  <= start_idx;
            beat_r <= '0;
            len_r  <= req_len;
            id_r   <= req_id;
            err_r  <= req_err;
          end
        end
        WDATA: begin
          if (s00_axi_wvalid) begin
            idx_r  <= idx_r + lg_els_lp'(1);
            beat_r <= beat_r + 8'd1;
            // wlast must mark exactly the final beat; early or missing both flag the burst.
            if (last_beat != s00_axi_wlast) err_r <= 1'b1;
          end
        end
        RFETCH: begin
          rdata_r <= fetch_word;
          idx_r   <= idx_r + lg_els_lp'(1);
        end
        RDATA: begin
          // Prefetch on acceptance so back-to-back beats need no bubble.
          if (s00_axi_rready && !last_beat) begin
            rdata_r <= fetch_word;
            idx_r   <= idx_r + lg_els_lp'(1);
            beat_r  <= beat_r + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (state_r == WDATA && s00_axi_wvalid && !err_r) begin
      for (int b = 0; b < bytes_lp; b++) begin
        if (s00_axi_wstrb[b]) mem[idx_r][b*8 +: 8] <= s00_axi_wdata[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_bsg_axi_mem_responder.sv
// Directed bench for bsg_axi_mem_responder: a word-array model predicts every R and B
// response, and one negedge process compares them against the DUT.
module tb_bsg_axi_mem_responder;

  localparam int els = 1024;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] awaddr = '0;
  logic [5:0]  awid = '0;
  logic [7:0]  awlen = '0;
  logic [1:0]  awburst = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [5:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [31:0] araddr = '0;
  logic [5:0]  arid = '0;
  logic [7:0]  arlen = '0;
  logic [1:0]  arburst = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [5:0]  rid;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready = 1'b0;

  always #5 aclk = ~aclk;

  bsg_axi_mem_responder #(
    .data_width_p(32), .addr_width_p(32), .id_width_p(6), .els_p(els)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s00_axi_awaddr(awaddr), .s00_axi_awid(awid), .s00_axi_awlen(awlen),
    .s00_axi_awburst(awburst), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wlast(wlast),
    .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
    .s00_axi_bid(bid), .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
    .s00_axi_araddr(araddr), .s00_axi_arid(arid), .s00_axi_arlen(arlen),
    .s00_axi_arburst(arburst), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rid(rid), .s00_axi_rresp(rresp),
    .s00_axi_rlast(rlast), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: byte-addressed word array, round-robin preference, expected responses.
  logic [31:0] model_mem [els];
  logic        model_rr_w;
  logic [40:0] exp_q[$];    // {data, resp, last, id}
  logic [7:0]  exp_b_q[$];  // {id, resp}
  logic [31:0] rx_q[$];
  logic [31:0] wd [16];
  logic [3:0]  ws [16];

  function automatic logic model_err(input logic [31:0] addr, input logic [7:0] len,
                                     input logic [1:0] burst);
    longint unsigned first = longint'(addr) / 4;
    return (burst != 2'b01) || (first + longint'(len) >= els);
  endfunction

  function automatic void model_store(input int idx, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++)
      if (s[b]) model_mem[idx][b*8 +: 8] = d[b*8 +: 8];
  endfunction

  function automatic void push_reads(input logic [31:0] addr, input logic [7:0] len,
                                     input logic [1:0] burst, input logic [5:0] id);
    logic e = model_err(addr, len, burst);
    for (int i = 0; i <= int'(len); i++) begin
      logic [31:0] d = e ? 32'h0 : model_mem[(int'(addr / 4) + i) % els];
      exp_q.push_back({d, (e ? 2'b10 : 2'b00), (i == int'(len)), id});
    end
  endfunction

  // Compare process.
  logic [40:0] r_cur;
  logic [40:0] prev_r;
  logic        prev_stall;
  assign r_cur = {rdata, rresp, rlast, rid};

  always @(negedge aclk) begin
    if (!aresetn) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) check("r_hold_while_stalled", r_cur, prev_r);
      if (rvalid) begin
        if (exp_q.size() == 0) check("r_unexpected_valid", rvalid, 1'b0);
        else if (rready) begin
          check("r_beat", r_cur, exp_q.pop_front());
          rx_q.push_back(rdata);
        end
      end
      if (bvalid && bready) begin
        if (exp_b_q.size() == 0) check("b_unexpected_valid", bvalid, 1'b0);
        else check("b_resp", {bid, bresp}, exp_b_q.pop_front());
      end
      prev_stall <= rvalid && !rready;
      prev_r     <= r_cur;
    end
  end

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic do_aw(input logic [31:0] addr, input logic [5:0] id, input logic [7:0] len,
                       input logic [1:0] burst);
    int n = 0;
    awaddr = addr; awid = id; awlen = len; awburst = burst; awvalid = 1'b1;
    @(negedge aclk);
    while (!awready && n < 40) begin
      @(negedge aclk);
      n++;
    end
    check("aw_accept", awready, 1'b1);
    tick;
    awvalid = 1'b0;
    model_rr_w = 1'b0;
  endtask

  // early_last >= 0 raises wlast on that beat as well; beats after it are not stored.
  task automatic do_write(input logic [31:0] addr, input logic [5:0] id, input logic [7:0] len,
                          input logic [1:0] burst, input int early_last);
    logic store = !model_err(addr, len, burst);
    logic e     = !store || (early_last >= 0);
    int   n     = 0;
    do_aw(addr, id, len, burst);
    for (int i = 0; i <= int'(len); i++) begin
      wvalid = 1'b1; wdata = wd[i]; wstrb = ws[i];
      wlast  = (i == int'(len)) || (i == early_last);
      @(negedge aclk);
      check("w_ready", wready, 1'b1);
      tick;
      if (store) model_store((int'(addr / 4) + i) % els, wd[i], ws[i]);
      if (i == early_last) store = 1'b0;
    end
    wvalid = 1'b0; wlast = 1'b0;
    @(negedge aclk);
    check("b_turnaround", bvalid, 1'b1);
    exp_b_q.push_back({id, (e ? 2'b10 : 2'b00)});
    tick;
    bready = 1'b1;
    @(negedge aclk);
    while (!bvalid && n < 20) begin
      @(negedge aclk);
      n++;
    end
    tick;
    bready = 1'b0;
    check("b_drained", exp_b_q.size(), 0);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [5:0] id, input logic [7:0] len,
                         input logic [1:0] burst, input logic toggle);
    int n = 0;
    int k = 0;
    push_reads(addr, len, burst, id);
    rx_q.delete();
    araddr = addr; arid = id; arlen = len; arburst = burst; arvalid = 1'b1;
    @(negedge aclk);
    while (!arready && n < 40) begin
      @(negedge aclk);
      n++;
    end
    check("ar_accept", arready, 1'b1);
    tick;
    arvalid = 1'b0;
    model_rr_w = 1'b1;
    @(negedge aclk);
    check("r_not_yet_valid", rvalid, 1'b0);
    tick;
    rready = 1'b1;
    @(negedge aclk);
    check("r_latency", rvalid, 1'b1);
    n = 0;
    while (exp_q.size() != 0 && n < 64) begin
      tick;
      k++; n++;
      rready = toggle ? (k % 2 == 0) : 1'b1;
    end
    if (exp_q.size() != 0) check("r_timeout", exp_q.size(), 0);
    rready = 1'b0;
  endtask

  initial begin
    int n;
    for (int i = 0; i < els; i++) model_mem[i] = '0;
    model_rr_w = 1'b1;

    // Reset state.
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_awready", awready, 1'b0);
    check("rst_arready", arready, 1'b0);
    check("rst_wready", wready, 1'b0);
    check("rst_bvalid", bvalid, 1'b0);
    check("rst_rvalid", rvalid, 1'b0);
    check("rst_r_fields", {rdata, rresp, rlast, rid}, 41'h0);
    check("rst_b_fields", {bid, bresp}, 8'h0);
    tick;
    aresetn = 1'b1;
    tick;

    // Simultaneous AW (0x10, id 5) and AR (0x10, id 3): write wins after reset.
    awaddr = 32'h10; awid = 6'd5; awlen = 8'd0; awburst = 2'b01; awvalid = 1'b1;
    araddr = 32'h10; arid = 6'd3; arlen = 8'd0; arburst = 2'b01; arvalid = 1'b1;
    @(negedge aclk);
    check("arb1_awready", awready, model_rr_w);
    check("arb1_arready", arready, !model_rr_w);
    check("arb1_write_first", awready, 1'b1);
    tick;
    awvalid = 1'b0;
    model_rr_w = 1'b0;
    wvalid = 1'b1; wdata = 32'hDEADBEEF; wstrb = 4'hF; wlast = 1'b1;
    @(negedge aclk);
    check("arb1_wready", wready, 1'b1);
    check("arb1_ar_held_off", arready, 1'b0);
    tick;
    wvalid = 1'b0; wlast = 1'b0;
    model_store(4, 32'hDEADBEEF, 4'hF);
    exp_b_q.push_back({6'd5, 2'b00});
    // Second pair: AR still waiting, a new AW arrives during the response phase.
    awaddr = 32'h40; awid = 6'd9; awlen = 8'd3; awburst = 2'b01; awvalid = 1'b1;
    bready = 1'b1;
    @(negedge aclk);
    check("wresp_no_aw", awready, 1'b0);
    check("wresp_no_ar", arready, 1'b0);
    tick;
    bready = 1'b0;
    push_reads(32'h10, 8'd0, 2'b01, 6'd3);
    rx_q.delete();
    @(negedge aclk);
    check("arb2_arready", arready, !model_rr_w);
    check("arb2_read_first", arready, 1'b1);
    check("arb2_awready", awready, 1'b0);
    tick;
    arvalid = 1'b0;
    model_rr_w = 1'b1;
    rready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      tick;
      n++;
    end
    rready = 1'b0;
    check("arb2_rx_lit", rx_q.size() > 0 ? rx_q[0] : 32'h0, 32'hDEADBEEF);
    for (int i = 0; i < 4; i++) begin wd[i] = i + 1; ws[i] = 4'hF; end
    do_write(32'h40, 6'd9, 8'd3, 2'b01, -1);

    // Single read with latency check.
    do_read(32'h10, 6'd3, 8'd0, 2'b01, 1'b0);
    check("single_lit", rx_q.size() > 0 ? rx_q[0] : 32'h0, 32'hDEADBEEF);

    // Burst read with rready 1,0,1,0.
    do_read(32'h40, 6'd12, 8'd3, 2'b01, 1'b1);
    check("burst_count", rx_q.size(), 4);
    for (int i = 0; i < 4; i++)
      check("burst_lit", rx_q.size() > i ? rx_q[i] : 32'h0, 32'(i + 1));

    // Partial strobe.
    wd[0] = 32'hFFFFFFFF; ws[0] = 4'hF;
    do_write(32'h20, 6'd1, 8'd0, 2'b01, -1);
    wd[0] = 32'h0000AAAA; ws[0] = 4'h3;
    do_write(32'h20, 6'd2, 8'd0, 2'b01, -1);
    do_read(32'h20, 6'd4, 8'd0, 2'b01, 1'b0);
    check("strobe_lit", rx_q.size() > 0 ? rx_q[0] : 32'h0, 32'hFFFFAAAA);

    // Error cases.
    wd[0] = 32'h0BADF00D; ws[0] = 4'hF;
    do_write(32'h0, 6'd6, 8'd0, 2'b01, -1);
    wd[0] = 32'h12345678;
    do_write(32'h1000, 6'd7, 8'd0, 2'b01, -1);
    do_write(32'h0, 6'd8, 8'd0, 2'b10, -1);
    do_read(32'h0, 6'd10, 8'd0, 2'b01, 1'b0);
    check("err_mem_unchanged", rx_q.size() > 0 ? rx_q[0] : 32'h0, 32'h0BADF00D);
    do_read(32'h0FFC, 6'd11, 8'd1, 2'b01, 1'b0);
    check("err_read_beats", rx_q.size(), 2);
    wd[0] = 32'h11111111; wd[1] = 32'h22222222; ws[0] = 4'hF; ws[1] = 4'hF;
    do_write(32'h80, 6'd13, 8'd1, 2'b01, 0);
    do_read(32'h0FFC, 6'd14, 8'd0, 2'b01, 1'b1);

    // Reset during beat 2 of a len-3 read.
    push_reads(32'h40, 8'd3, 2'b01, 6'd15);
    araddr = 32'h40; arid = 6'd15; arlen = 8'd3; arburst = 2'b01; arvalid = 1'b1;
    @(negedge aclk);
    check("rst_rd_ar_accept", arready, 1'b1);
    tick;
    arvalid = 1'b0;
    rready = 1'b1;
    n = 0;
    while (exp_q.size() > 3 && n < 20) begin
      tick;
      n++;
    end
    check("rst_rd_first_beat", exp_q.size(), 3);
    aresetn = 1'b0;
    #1;
    check("rst_rd_rvalid_drop", rvalid, 1'b0);
    exp_q.delete();
    model_rr_w = 1'b1;
    rready = 1'b0;
    tick;
    tick;
    aresetn = 1'b1;
    repeat (4) tick;
    do_read(32'h10, 6'd16, 8'd0, 2'b01, 1'b0);
    check("post_rst_lit", rx_q.size() > 0 ? rx_q[0] : 32'h0, 32'hDEADBEEF);

    repeat (3) tick;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
